// File: rtl/kogge_stone_bist.sv
// kogge_stone_bist: exhaustive self-test driver/checker for a combinational adder.
// Walks every {A,B,Cin} vector, holds each one for SETTLE_CYC cycles, then compares against A+B+Cin.
module kogge_stone_bist #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  output logic               dut_cin,
  input  logic [WIDTH-1:0]   dut_sum,
  input  logic               dut_cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic               fail_valid,
  output logic [2*WIDTH:0]   fail_vec,
  output logic [WIDTH:0]     fail_got,
  output logic [2*WIDTH:0]   vec_idx
);
  localparam int VW = 2*WIDTH+1;
  localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   vec_idx_q, vec_idx_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic            fail_valid_q, fail_valid_d;
  logic [VW-1:0]   fail_vec_q, fail_vec_d;
  logic [WIDTH:0]  fail_got_q, fail_got_d;
  logic [WIDTH:0]  got, expected;
  logic            accept, last, mismatch, capture;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      vec_idx_q    <= '0;
      err_count_q  <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_got_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vec_idx_q    <= vec_idx_d;
      err_count_q  <= err_count_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_got_q   <= fail_got_d;
    end
  end
  assign last = &vec_idx_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = start ? SETTLE : state_q;
      SETTLE:     state_d = (cnt_q == CW'(SETTLE_CYC-1)) ? CHECK : SETTLE;
      CHECK:      state_d = last ? DONE : SETTLE;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = (state_q == SETTLE) || (state_q == CHECK);
    done = state_q == DONE;
    pass = done && (err_count_q == '0);
  end
  // Case inequality so an X/Z response from the adder is always a mismatch.
  always_comb begin
    got          = {dut_cout, dut_sum};
    expected     = {1'b0, dut_a} + {1'b0, dut_b} + (WIDTH+1)'(dut_cin);
    accept       = ((state_q == IDLE) || (state_q == DONE)) && start;
    mismatch     = (state_q == CHECK) && (got !== expected);
    capture      = mismatch && !fail_valid_q;
    cnt_d        = (state_q == SETTLE) ? cnt_q + CW'(1) : '0;
    vec_idx_d    = accept ? '0 : ((state_q == CHECK) && !last) ? vec_idx_q + VW'(1) : vec_idx_q;
    err_count_d  = accept ? '0 : (mismatch && !(&err_count_q)) ? err_count_q + ERR_W'(1) : err_count_q;
    fail_valid_d = accept ? 1'b0 : fail_valid_q | mismatch;
    fail_vec_d   = accept ? '0 : capture ? vec_idx_q : fail_vec_q;
    fail_got_d   = accept ? '0 : capture ? got : fail_got_q;
  end
  assign {dut_a, dut_b, dut_cin} = vec_idx_q;
  assign vec_idx    = vec_idx_q;
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_got   = fail_got_q;
endmodule

// File: tb/tb_kogge_stone_bist.sv
// tb_kogge_stone_bist: two BIST instances (settle 1 / 16-bit count, settle 3 / 4-bit count) against
// a behavioural adder with selectable faults and a timing-formula reference model.
module tb_kogge_stone_bist;
  localparam int N  = 512;
  localparam int S0 = 1;
  localparam int S1 = 3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  always #5 clk = ~clk;
  int mode = 0;
  logic [4:0] flip [N];
  int errors = 0, checks = 0;
  logic [3:0] a [2], b [2], sum [2];
  logic       cin [2], cout [2], busy [2], done [2], pass [2], fv [2];
  logic [8:0] vi [2], fvec [2];
  logic [4:0] fg [2];
  logic [15:0] ec0;
  logic [3:0]  ec1;
  kogge_stone_bist #(.WIDTH(4), .SETTLE_CYC(S0), .ERR_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(a[0]), .dut_b(b[0]), .dut_cin(cin[0]),
    .dut_sum(sum[0]), .dut_cout(cout[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(ec0), .fail_valid(fv[0]), .fail_vec(fvec[0]), .fail_got(fg[0]), .vec_idx(vi[0]));
  kogge_stone_bist #(.WIDTH(4), .SETTLE_CYC(S1), .ERR_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(a[1]), .dut_b(b[1]), .dut_cin(cin[1]),
    .dut_sum(sum[1]), .dut_cout(cout[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(ec1), .fail_valid(fv[1]), .fail_vec(fvec[1]), .fail_got(fg[1]), .vec_idx(vi[1]));

  function automatic logic [4:0] ideal(input logic [8:0] k);
    return {1'b0, k[8:5]} + {1'b0, k[4:1]} + 5'(k[0]);
  endfunction
  // Adder under test: mode 0 correct, 1 sum[0] stuck-at-0, 2 random bit flips, 3 two-cycle latency.
  function automatic logic [4:0] faulty(input int m, input logic [8:0] k);
    return m == 1 ? ideal(k) & 5'h1e : m == 2 ? ideal(k) ^ flip[k] : ideal(k);
  endfunction
  logic [4:0] p0a, p0b, p1a, p1b;
  always @(posedge clk) begin
    p0a <= ideal({a[0], b[0], cin[0]}); p0b <= p0a;
    p1a <= ideal({a[1], b[1], cin[1]}); p1b <= p1a;
  end
  assign {cout[0], sum[0]} = mode == 3 ? p0b : faulty(mode, {a[0], b[0], cin[0]});
  assign {cout[1], sum[1]} = mode == 3 ? p1b : faulty(mode, {a[1], b[1], cin[1]});

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: n = edges since the accepted start; the fault setup is snapshotted at accept.
  bit act [2];
  int n [2], rmode [2];
  logic [4:0] rflip [2][N];
  initial for (int i = 0; i < 2; i++) begin act[i] = 0; n[i] = 0; rmode[i] = 0; end
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin act[i] = 0; n[i] = 0; end
      else if (start && (!act[i] || n[i] >= N * ((i == 1 ? S1 : S0) + 1))) begin
        act[i] = 1; n[i] = 0; rmode[i] = mode;
        for (int k = 0; k < N; k++) rflip[i][k] = flip[k];
      end else if (act[i]) n[i]++;
    end
  function automatic logic [4:0] model_got(input int i, input int k);
    return rmode[i] == 1 ? ideal(9'(k)) & 5'h1e : rmode[i] == 2 ? ideal(9'(k)) ^ rflip[i][k] : ideal(9'(k));
  endfunction
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      int sp, c, v, cnt, first, emax;
      logic [4:0] g, gfirst;
      sp = (i == 1 ? S1 : S0) + 1;
      if (!(rmode[i] == 3 && sp < 3)) begin
        c = act[i] ? ((n[i] / sp > N) ? N : n[i] / sp) : 0;
        v = act[i] ? ((n[i] / sp > N - 1) ? N - 1 : n[i] / sp) : 0;
        cnt = 0; first = -1; gfirst = 0;
        for (int k = 0; k < c; k++) begin
          g = model_got(i, k);
          if (g != ideal(9'(k))) begin
            cnt++;
            if (first < 0) begin first = k; gfirst = g; end
          end
        end
        emax = i == 1 ? 15 : 65535;
        if (cnt > emax) cnt = emax;
        chk($sformatf("u%0d.vec_idx", i), 32'(vi[i]), v);
        chk($sformatf("u%0d.dut_abc", i), 32'({a[i], b[i], cin[i]}), v);
        chk($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(act[i] && n[i] < N * sp));
        chk($sformatf("u%0d.done", i), 32'(done[i]), 32'(act[i] && n[i] >= N * sp));
        chk($sformatf("u%0d.pass", i), 32'(pass[i]), 32'(act[i] && n[i] >= N * sp && cnt == 0));
        chk($sformatf("u%0d.err_count", i), i == 1 ? 32'(ec1) : 32'(ec0), cnt);
        chk($sformatf("u%0d.fail_valid", i), 32'(fv[i]), 32'(first >= 0));
        chk($sformatf("u%0d.fail_vec", i), 32'(fvec[i]), first >= 0 ? first : 0);
        chk($sformatf("u%0d.fail_got", i), 32'(fg[i]), 32'(gfirst));
      end
    end

  int dn, fe;
  // One pulse of start, optional extra start pulse at edge 'poke', then wait for both instances.
  task automatic run(input int m, input int poke);
    int e;
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; e = 0; dn = -1; fe = -1;
    chk("restart_done_drop", 32'(done[0]), 0);
    chk("restart_busy", 32'(busy[0]), 1);
    chk("restart_err_clear", 32'(ec0), 0);
    while (!(done[0] && done[1]) && e < 5000) begin
      if (dn < 0 && done[0]) dn = e;
      if (fe < 0 && fv[0]) fe = e;
      start = (e == poke);
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    chk("run_timeout", 32'(done[0] && done[1]), 1);
  endtask

  initial begin
    for (int k = 0; k < N; k++) flip[k] = 0;
    repeat (2) @(negedge clk);
    chk("reset_done", 32'(done[0]), 0);
    chk("reset_vec", 32'(vi[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 74);
    chk("clean_done_edge", dn, 1024);
    chk("clean_pass", 32'(pass[0]), 1);
    chk("clean_vec_last", 32'(vi[0]), 511);
    chk("clean_pass_u1", 32'(pass[1]), 1);
    run(1, -1);
    chk("stuck_err", 32'(ec0), 256);
    chk("stuck_first_edge", fe, 4);
    chk("stuck_fail_vec", 32'(fvec[0]), 32'h001);
    chk("stuck_fail_got", 32'(fg[0]), 0);
    chk("stuck_pass", 32'(pass[0]), 0);
    chk("stuck_sat_u1", 32'(ec1), 15);
    chk("stuck_vec_u1", 32'(fvec[1]), 32'h001);
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 1000 && vi[0] != 9'd100; g++) @(negedge clk);
    chk("reach_vec100", 32'(vi[0]), 100);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy[0]), 0);
    chk("midrst_vec", 32'(vi[0]), 0);
    chk("midrst_abc", 32'({a[1], b[1], cin[1]}), 0);
    run(0, -1);
    chk("post_rst_pass", 32'(pass[0]), 1);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) flip[k] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      run(2, int'($urandom_range(0, 900)));
    end
    run(3, -1);
    chk("delay_pass_u1", 32'(pass[1]), 1);
    chk("delay_fv_u0", 32'(fv[0]), 1);
    chk("delay_err_u0", 32'(ec0 != 0), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
